// File: rtl/k12a_loader_arbiter_pkg.sv
// Shared types and constants for the k12a loader/debug bus arbiter.
package k12a_loader_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_STOP,
        ARB_OWN,
        ARB_RD,
        ARB_WSET,
        ARB_WPUL,
        ARB_WHLD,
        ARB_REL
    } arb_state_t;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_mode_t;

    localparam logic BUS_OWNER_CPU    = 1'b0;
    localparam logic BUS_OWNER_LOADER = 1'b1;

    // States in which the loader drives the memory bus.
    function automatic logic is_loader_owned(input arb_state_t s);
        return s inside {ARB_OWN, ARB_RD, ARB_WSET, ARB_WPUL, ARB_WHLD};
    endfunction

endpackage

// File: rtl/k12a_loader_timer.sv
// Phase timer for the loader arbiter: 4-bit down-counter whose done flag marks
// the last cycle of a timed RD/WSET/WPUL phase.
module k12a_loader_timer (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/k12a_loader_arbiter.sv
// Hands the k12a memory bus between the CPU and the loader/debug port.
// Optional K12A_LOADER_AUTOINC_EN: per-session auto-incrementing transfer address.
module k12a_loader_arbiter
    import k12a_loader_arbiter_pkg::*;
#(
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 2
) (
    input  logic        cpu_clock,
    input  logic        reset,
    input  logic        cpu_at_boundary,
    output logic        cpu_hold,
    input  logic        cpu_mem_enable,
    input  logic        cpu_mem_write,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        ld_session,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic        ld_ack,
    output logic [7:0]  ld_rdata,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        async_write,
    output logic        bus_owner
);

    localparam logic [3:0] WR_SETUP_C = 4'(WR_SETUP);
    localparam logic [3:0] WR_PULSE_C = 4'(WR_PULSE);
    localparam logic [3:0] RD_WAIT_C  = 4'(RD_WAIT);

    arb_state_t  state_q, state_d;
    logic [15:0] xaddr_q, xaddr_d;
    logic [7:0]  xdata_q, xdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] next_addr;
    logic        tmr_load;
    logic [3:0]  tmr_val;
    logic        tmr_done;
    mem_mode_t   mode;

    k12a_loader_timer u_timer (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .done      (tmr_done)
    );

`ifdef K12A_LOADER_AUTOINC_EN
    logic [15:0] acnt_q, acnt_d;
    logic        armed_q, armed_d;

    always_comb begin
        acnt_d  = acnt_q;
        armed_d = armed_q;
        if ((state_q == ARB_OWN) && ld_req && armed_q) begin
            acnt_d  = ld_addr;
            armed_d = 1'b0;
        end
        if (ld_ack) begin
            acnt_d = acnt_q + 16'd1;
        end
        if (state_q == ARB_REL) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            acnt_q  <= 16'd0;
            armed_q <= 1'b1;
        end else begin
            acnt_q  <= acnt_d;
            armed_q <= armed_d;
        end
    end

    assign next_addr = armed_q ? ld_addr : acnt_q;
`else
    assign next_addr = ld_addr;
`endif

    always_comb begin
        state_d  = state_q;
        xaddr_d  = xaddr_q;
        xdata_d  = xdata_q;
        rdata_d  = rdata_q;
        tmr_load = 1'b0;
        tmr_val  = 4'd0;
        ld_ack   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (ld_session) state_d = ARB_STOP;
            end
            ARB_STOP: begin
                if (!ld_session) begin
                    state_d = ARB_REL;
                end else if (cpu_at_boundary) begin
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                // A pending request wins over a session drop in the same cycle.
                if (ld_req) begin
                    xaddr_d  = next_addr;
                    tmr_load = 1'b1;
                    if (ld_we) begin
                        xdata_d = ld_wdata;
                        tmr_val = WR_SETUP_C;
                        state_d = ARB_WSET;
                    end else begin
                        tmr_val = RD_WAIT_C;
                        state_d = ARB_RD;
                    end
                end else if (!ld_session) begin
                    state_d = ARB_REL;
                end
            end
            ARB_RD: begin
                if (tmr_done) begin
                    rdata_d = mem_rdata;
                    ld_ack  = 1'b1;
                    state_d = ARB_OWN;
                end
            end
            ARB_WSET: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = WR_PULSE_C;
                    state_d  = ARB_WPUL;
                end
            end
            ARB_WPUL: begin
                if (tmr_done) state_d = ARB_WHLD;
            end
            ARB_WHLD: begin
                ld_ack  = 1'b1;
                state_d = ARB_OWN;
            end
            ARB_REL: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
        xaddr_q <= xaddr_d;
        xdata_q <= xdata_d;
    end

    // Bus mux: all loader-side drive decodes from registered state only.
    always_comb begin
        mem_enable = cpu_mem_enable;
        mode       = cpu_mem_write ? MEM_WRITE : MEM_READ;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        case (state_q)
            ARB_OWN: begin
                mem_enable = 1'b0;
                mode       = MEM_READ;
                mem_addr   = xaddr_q;
                mem_wdata  = xdata_q;
            end
            ARB_RD: begin
                mem_enable = 1'b1;
                mode       = MEM_READ;
                mem_addr   = xaddr_q;
                mem_wdata  = xdata_q;
            end
            ARB_WSET, ARB_WPUL, ARB_WHLD: begin
                mem_enable = 1'b1;
                mode       = MEM_WRITE;
                mem_addr   = xaddr_q;
                mem_wdata  = xdata_q;
            end
            ARB_REL: begin
                mem_enable = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign mem_write   = (mode == MEM_WRITE);
    assign async_write = (state_q == ARB_WPUL);
    assign cpu_hold    = (state_q != ARB_IDLE);
    assign bus_owner   = is_loader_owned(state_q) ? BUS_OWNER_LOADER : BUS_OWNER_CPU;
    assign ld_rdata    = rdata_d;

endmodule

// File: tb/tb_k12a_loader_arbiter.sv
// Self-checking bench for k12a_loader_arbiter: per-cycle transaction timeline
// model plus literal checks; covers K12A_LOADER_AUTOINC_EN when defined.
module tb_k12a_loader_arbiter;

    localparam int WR_SETUP = 1;
    localparam int WR_PULSE = 2;
    localparam int RD_WAIT  = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_at_boundary, cpu_mem_enable, cpu_mem_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ld_session, ld_req, ld_we;
    logic [15:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        cpu_hold, ld_ack, mem_enable, mem_write, async_write, bus_owner;
    logic [7:0]  ld_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    k12a_loader_arbiter #(
        .WR_SETUP (WR_SETUP),
        .WR_PULSE (WR_PULSE),
        .RD_WAIT  (RD_WAIT)
    ) dut (
        .cpu_clock       (clk),
        .reset           (reset),
        .cpu_at_boundary (cpu_at_boundary),
        .cpu_hold        (cpu_hold),
        .cpu_mem_enable  (cpu_mem_enable),
        .cpu_mem_write   (cpu_mem_write),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .ld_session      (ld_session),
        .ld_req          (ld_req),
        .ld_we           (ld_we),
        .ld_addr         (ld_addr),
        .ld_wdata        (ld_wdata),
        .ld_ack          (ld_ack),
        .ld_rdata        (ld_rdata),
        .mem_enable      (mem_enable),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .async_write     (async_write),
        .bus_owner       (bus_owner)
    );

    // SRAM model: combinational read, write on the strobe.
    logic [7:0] tb_mem [0:65535];
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (async_write) tb_mem[mem_addr] <= mem_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, req_v, $time);
        end
    endtask

    // Expected outputs for the current cycle.
    logic        e_on = 1'b0;
    logic        e_hold, e_owner, e_aw, e_ack;
    logic        e_ce, e_ca, e_cd, e_en, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic [7:0]  m_rdata;
    logic [7:0]  aw_sh = 8'd0, ack_sh = 8'd0;
`ifdef K12A_LOADER_AUTOINC_EN
    logic        m_armed;
    logic [15:0] m_cnt;
`endif

    always @(negedge clk) begin
        aw_sh  <= {aw_sh[6:0], async_write};
        ack_sh <= {ack_sh[6:0], ld_ack};
        if (e_on) begin
            chk("cpu_hold", 16'(cpu_hold), 16'(e_hold));
            chk("bus_owner", 16'(bus_owner), 16'(e_owner));
            chk("async_write", 16'(async_write), 16'(e_aw));
            chk("ld_ack", 16'(ld_ack), 16'(e_ack));
            chk("ld_rdata", 16'(ld_rdata), 16'(m_rdata));
            if (e_ce) chk("mem_enable", 16'(mem_enable), 16'(e_en));
            if (e_ca) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_write", 16'(mem_write), 16'(e_wr));
            end
            if (e_cd) chk("mem_wdata", 16'(mem_wdata), 16'(e_wdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e_ce = 1'b0;
        e_ca = 1'b0;
        e_cd = 1'b0;
    endtask

    task automatic exp_ctl(input logic h, input logic o, input logic a, input logic k);
        e_hold  = h;
        e_owner = o;
        e_aw    = a;
        e_ack   = k;
    endtask

    task automatic exp_cpu_bus();
        e_ce    = 1'b1;
        e_ca    = 1'b1;
        e_cd    = 1'b1;
        e_en    = cpu_mem_enable;
        e_wr    = cpu_mem_write;
        e_addr  = cpu_addr;
        e_wdata = cpu_wdata;
    endtask

    task automatic exp_ldr_bus(input logic en, input logic wr, input logic [15:0] a,
                               input logic [7:0] d, input logic cd);
        e_ce    = 1'b1;
        e_ca    = en;
        e_cd    = cd;
        e_en    = en;
        e_wr    = wr;
        e_addr  = a;
        e_wdata = d;
    endtask

    // Address a transfer must use, given the address the loader presented.
    function automatic logic [15:0] eff_addr(input logic [15:0] la);
`ifdef K12A_LOADER_AUTOINC_EN
        logic [15:0] a;
        a       = m_armed ? la : m_cnt;
        m_armed = 1'b0;
        m_cnt   = a + 16'd1;
        return a;
`else
        return la;
`endif
    endfunction

    task automatic start_session(input int nwait);
        tick();
        ld_session = 1'b1;
        cpu_at_boundary = 1'b0;
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();
        for (int k = 0; k < nwait; k++) begin
            tick();
            cpu_addr = cpu_addr + 16'd3;
            exp_ctl(1'b1, 1'b0, 1'b0, 1'b0);
            exp_cpu_bus();
        end
        tick();
        cpu_at_boundary = 1'b1;
        exp_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();
    endtask

    // mode 0: plain write; 1: drop session in first pulse cycle; 2: reset there.
    task automatic do_write(input logic [15:0] la, input logic [7:0] d, input int mode);
        logic [15:0] ea;
        int n;
        n = WR_SETUP + WR_PULSE + 1;
        tick();
        cpu_at_boundary = 1'b0;
        ld_req = 1'b1;
        ld_we = 1'b1;
        ld_addr = la;
        ld_wdata = d;
        ea = eff_addr(la);
        exp_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        exp_ldr_bus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        for (int i = 1; i <= n; i++) begin
            tick();
            ld_addr = ~la;
            ld_wdata = ~d;
            if (i == WR_SETUP + 1 && mode == 1) ld_session = 1'b0;
            if (i == WR_SETUP + 1 && mode == 2) reset = 1'b1;
            exp_ctl(1'b1, 1'b1, (i > WR_SETUP && i <= WR_SETUP + WR_PULSE), (i == n));
            exp_ldr_bus(1'b1, 1'b1, ea, d, 1'b1);
            if (i == WR_SETUP + 1 && mode == 2) break;
        end
    endtask

    task automatic do_read(input logic [15:0] la, input logic [7:0] d);
        logic [15:0] ea;
        tick();
        cpu_at_boundary = 1'b0;
        ld_req = 1'b1;
        ld_we = 1'b0;
        ld_addr = la;
        ea = eff_addr(la);
        exp_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        exp_ldr_bus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        for (int i = 1; i <= RD_WAIT; i++) begin
            tick();
            ld_addr = ~la;
            if (i == RD_WAIT) m_rdata = d;
            exp_ctl(1'b1, 1'b1, 1'b0, (i == RD_WAIT));
            exp_ldr_bus(1'b1, 1'b0, ea, 8'd0, 1'b0);
        end
    endtask

    task automatic own_idle(input logic sess);
        tick();
        ld_req = 1'b0;
        ld_session = sess;
        exp_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        exp_ldr_bus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    endtask

    // One dead REL cycle, then the CPU owns the bus again.
    task automatic release_bus(input logic [15:0] new_cpu_addr);
        tick();
        exp_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        exp_ldr_bus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
`ifdef K12A_LOADER_AUTOINC_EN
        m_armed = 1'b1;
`endif
        tick();
        cpu_addr = new_cpu_addr;
        cpu_wdata = cpu_wdata + 8'd1;
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();
    endtask

    initial begin
        reset = 1'b1;
        cpu_at_boundary = 1'b0;
        cpu_mem_enable = 1'b1;
        cpu_mem_write = 1'b0;
        cpu_addr = 16'h5555;
        cpu_wdata = 8'h3C;
        ld_session = 1'b0;
        ld_req = 1'b0;
        ld_we = 1'b0;
        ld_addr = 16'h0000;
        ld_wdata = 8'h00;
        m_rdata = 8'h00;
`ifdef K12A_LOADER_AUTOINC_EN
        m_armed = 1'b1;
        m_cnt = 16'h0000;
`endif
        @(posedge clk);
        #1;
        e_on = 1'b1;
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();
        tick();
        reset = 1'b0;
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();
        tick();
        cpu_mem_write = 1'b1;
        cpu_addr = 16'h0F0F;
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();

        // Session 1: freeze wait, write, then a write with the session dropped mid-pulse.
        start_session(5);
        do_write(16'h1234, 8'hA5, 0);
        own_idle(1'b1);
        chk("write_strobe_pattern", 16'(aw_sh[3:0]), 16'h0006);
        chk("write_ack_pattern", 16'(ack_sh[3:0]), 16'h0001);
        chk("sram_1234", 16'(tb_mem[16'h1234]), 16'h00A5);
        do_write(16'h2000, 8'h77, 1);
        own_idle(1'b0);
        release_bus(16'hBEEF);
`ifdef K12A_LOADER_AUTOINC_EN
        chk("sram_1235", 16'(tb_mem[16'h1235]), 16'h0077);
`else
        chk("sram_2000", 16'(tb_mem[16'h2000]), 16'h0077);
`endif

        // Session 2: read back, then reset in the middle of a write pulse.
        start_session(0);
        do_read(16'h1234, 8'hA5);
        own_idle(1'b1);
        chk("rdata_held", 16'(ld_rdata), 16'h00A5);
        do_write(16'h3000, 8'h99, 2);
        tick();
        reset = 1'b0;
        ld_session = 1'b0;
        ld_req = 1'b0;
        m_rdata = 8'h00;
`ifdef K12A_LOADER_AUTOINC_EN
        m_armed = 1'b1;
`endif
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();
        tick();
        cpu_addr = 16'h7001;
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();

        // Session 3.
`ifdef K12A_LOADER_AUTOINC_EN
        start_session(1);
        do_write(16'hFFFE, 8'h11, 0);
        own_idle(1'b1);
        do_write(16'h0000, 8'h22, 0);
        own_idle(1'b1);
        do_write(16'h0000, 8'h33, 0);
        own_idle(1'b1);
        do_write(16'h0000, 8'h44, 0);
        own_idle(1'b0);
        release_bus(16'h0123);
        chk("autoinc_fffe", 16'(tb_mem[16'hFFFE]), 16'h0011);
        chk("autoinc_ffff", 16'(tb_mem[16'hFFFF]), 16'h0022);
        chk("autoinc_0000", 16'(tb_mem[16'h0000]), 16'h0033);
        chk("autoinc_0001", 16'(tb_mem[16'h0001]), 16'h0044);
`else
        start_session(2);
        do_write(16'h4321, 8'h5C, 0);
        own_idle(1'b1);
        do_read(16'h4321, 8'h5C);
        own_idle(1'b0);
        release_bus(16'h0123);
        chk("readback_4321", 16'(ld_rdata), 16'h005C);
`endif
        tick();
        exp_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        exp_cpu_bus();
        tick();
        e_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
